jt900h_intctl: RTL and testbench

- Interrupt priority controller for the JT900H core.
- Latches requests from NSRC peripheral sources and holds a per-source priority, programmed through the control-register write bus (cra/crin/cr_we) that the register file drives.
- Arbitrates pending requests against the current IFF mask and hands the control unit one winner through a req/ack handshake.
- Drives the int_lvl and int_addr inputs that the register file muxes onto its operand path during interrupt entry.

---
 rtl/jt900h_intctl_pkg.sv | 24 ++
 rtl/jt900h_intprio.sv | 34 +++
 rtl/jt900h_intctl.sv | 166 ++++++++++++++++
 tb/tb_jt900h_intctl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_intctl_pkg.sv
// Shared types and constants for the JT900H interrupt controller.
// Optional per-source level mode is enabled with INTCTL_LEVEL_EN.
package jt900h_intctl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } intctl_state_t;

   localparam logic [7:0] CRA_BASE_DEF = 8'h70;
   localparam logic [7:0] VBASE_DEF    = 8'h40;
   localparam logic [2:0] NMI_LVL      = 3'd7;

   // IFF value loaded on entry: one above the served priority, saturating at NMI.
   function automatic logic [2:0] next_iff(input logic [2:0] p);
      return (p == NMI_LVL) ? NMI_LVL : p + 3'd1;
   endfunction

   function automatic logic [7:0] vec_addr(input logic [7:0] vbase, input logic [3:0] idx);
      return vbase + {2'b00, idx, 2'b00};
   endfunction

endpackage

// File: rtl/jt900h_intprio.sv
// Combinational priority encoder: highest eligible priority wins, lowest index on ties.
module jt900h_intprio
   import jt900h_intctl_pkg::*;
#(
   parameter int NSRC = 8
)(
   input  logic [NSRC-1:0]   i_pending,
   input  logic [3*NSRC-1:0] i_prio,
   input  logic [2:0]        i_riff,
   output logic              o_any,
   output logic [3:0]        o_idx,
   output logic [2:0]        o_prio
);

   logic [2:0] w_p;

   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      o_prio = '0;
      w_p    = '0;
      // Strict '>' keeps the earlier (lower) index when priorities tie.
      for (int unsigned i = 0; i < NSRC; i++) begin
         w_p = i_prio[3*i +: 3];
         if (i_pending[i] && (w_p != 3'd0) && ((w_p > i_riff) || (w_p == NMI_LVL))
             && (w_p > o_prio)) begin
            o_any  = 1'b1;
            o_idx  = 4'(i);
            o_prio = w_p;
         end
      end
   end

endmodule

// File: rtl/jt900h_intctl.sv
// JT900H interrupt priority controller: request latching, CR access, arbitration and req/ack FSM.
// Define INTCTL_LEVEL_EN to add a per-source level-sensitive mode bit (crin[3] / cr_rd[3]).
module jt900h_intctl
   import jt900h_intctl_pkg::*;
#(
   parameter int         NSRC     = 8,
   parameter logic [7:0] CRA_BASE = CRA_BASE_DEF,
   parameter logic [7:0] VBASE    = VBASE_DEF
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic [NSRC-1:0] irq,
   input  logic [2:0]      riff,
   input  logic [7:0]      cra,
   input  logic [31:0]     crin,
   input  logic            cr_we,
   output logic [7:0]      cr_rd,
   output logic            cr_hit,
   output logic            int_req,
   input  logic            int_ack,
   output logic [2:0]      int_lvl,
   output logic [7:0]      int_addr
);

   logic [3*NSRC-1:0] r_prio;
   logic [NSRC-1:0]   r_pend;
   logic [NSRC-1:0]   r_irq_l;
   logic [NSRC-1:0]   w_level;

   intctl_state_t     r_state, w_state_nx;
   logic [3:0]        r_idx, w_idx_nx;
   logic              r_req, w_req_nx;
   logic [2:0]        r_lvl, w_lvl_nx;
   logic [7:0]        r_addr, w_addr_nx;

   logic [7:0]        w_off;
   logic              w_hit;
   logic [NSRC-1:0]   w_wr_sel;
   logic [NSRC-1:0]   w_pend_nx;
   logic              w_any;
   logic [3:0]        w_widx;
   logic [2:0]        w_wprio;

   assign w_off  = cra - CRA_BASE;
   assign w_hit  = (w_off < 8'(NSRC));
   assign cr_hit = w_hit;

   always_comb begin
      cr_rd    = '0;
      w_wr_sel = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (w_hit && (w_off == 8'(i))) begin
            cr_rd       = {r_pend[i], 3'b000, w_level[i], r_prio[3*i +: 3]};
            w_wr_sel[i] = cr_we;
         end
      end
   end

`ifdef INTCTL_LEVEL_EN
   logic [NSRC-1:0] r_level;
   logic            w_unused_crin;

   assign w_level       = r_level;
   assign w_unused_crin = ^{crin[31:8], crin[6:4]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
      end else if (cen) begin
         for (int unsigned i = 0; i < NSRC; i++)
            if (w_wr_sel[i]) r_level[i] <= crin[3];
      end
   end
`else
   logic w_unused_crin;

   assign w_level       = '0;
   assign w_unused_crin = ^{crin[31:8], crin[6:3]};
`endif

   // Ack clear beats a new edge for the served source; an edge beats a CR clear.
   always_comb begin
      w_pend_nx = r_pend;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if ((r_state == ST_ACK) && (r_idx == 4'(i)))
            w_pend_nx[i] = 1'b0;
         else if (irq[i] && !r_irq_l[i])
            w_pend_nx[i] = 1'b1;
         else if (w_wr_sel[i] && crin[7])
            w_pend_nx[i] = 1'b0;
         if (w_level[i])
            w_pend_nx[i] = irq[i];
      end
   end

   jt900h_intprio #(
      .NSRC (NSRC)
   ) u_prio (
      .i_pending (r_pend),
      .i_prio    (r_prio),
      .i_riff    (riff),
      .o_any     (w_any),
      .o_idx     (w_widx),
      .o_prio    (w_wprio)
   );

   // Winner data is captured on the IDLE->REQ transition and never touched in REQ/ACK.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_req_nx   = r_req;
      w_lvl_nx   = r_lvl;
      w_addr_nx  = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nx = ST_REQ;
               w_idx_nx   = w_widx;
               w_req_nx   = 1'b1;
               w_lvl_nx   = next_iff(w_wprio);
               w_addr_nx  = vec_addr(VBASE, w_widx);
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               w_state_nx = ST_ACK;
               w_req_nx   = 1'b0;
            end
         end
         ST_ACK:  w_state_nx = ST_IDLE;
         default: begin
            w_state_nx = ST_IDLE;
            w_req_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio  <= '0;
         r_pend  <= '0;
         r_irq_l <= '0;
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_req   <= 1'b0;
         r_lvl   <= '0;
         r_addr  <= '0;
      end else if (cen) begin
         r_pend  <= w_pend_nx;
         r_irq_l <= irq;
         for (int unsigned i = 0; i < NSRC; i++)
            if (w_wr_sel[i]) r_prio[3*i +: 3] <= crin[2:0];
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_req   <= w_req_nx;
         r_lvl   <= w_lvl_nx;
         r_addr  <= w_addr_nx;
      end
   end

   assign int_req  = r_req;
   assign int_lvl  = r_lvl;
   assign int_addr = r_addr;

endmodule

// File: tb/tb_jt900h_intctl.sv
// Self-checking bench for jt900h_intctl: directed scenarios plus randomized traffic against a reference model.
module tb_jt900h_intctl;

   localparam int         NSRC     = 8;
   localparam logic [7:0] CRA_BASE = 8'h70;
   localparam logic [7:0] VBASE    = 8'h40;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            cen = 1'b1;
   logic [NSRC-1:0] irq = '0;
   logic [2:0]      riff = '0;
   logic [7:0]      cra = '0;
   logic [31:0]     crin = '0;
   logic            cr_we = 1'b0;
   logic            int_ack = 1'b0;
   logic [7:0]      cr_rd;
   logic            cr_hit;
   logic            int_req;
   logic [2:0]      int_lvl;
   logic [7:0]      int_addr;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   jt900h_intctl #(
      .NSRC     (NSRC),
      .CRA_BASE (CRA_BASE),
      .VBASE    (VBASE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .irq      (irq),
      .riff     (riff),
      .cra      (cra),
      .crin     (crin),
      .cr_we    (cr_we),
      .cr_rd    (cr_rd),
      .cr_hit   (cr_hit),
      .int_req  (int_req),
      .int_ack  (int_ack),
      .int_lvl  (int_lvl),
      .int_addr (int_addr)
   );

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-source arrays plus a "serving" record (phase 0 idle, 1 requesting, 2 acked).
   int m_prio[NSRC] = '{default: 0};
   int m_pend[NSRC] = '{default: 0};
   int m_irql[NSRC] = '{default: 0};
   int m_lvb[NSRC]  = '{default: 0};
   int m_phase = 0, m_idx = 0, m_req = 0, m_lvl = 0, m_addr = 0;
   int best, bp, wn;
   bit wr;

   function automatic int exp_hit(input logic [7:0] a);
      int n = int'(a) - int'(CRA_BASE);
      return (n >= 0 && n < NSRC) ? 1 : 0;
   endfunction

   function automatic int exp_rd(input logic [7:0] a);
      int n = int'(a) - int'(CRA_BASE);
      if (n < 0 || n >= NSRC) return 0;
      return (m_pend[n] << 7) | (m_lvb[n] << 3) | m_prio[n];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSRC; i++) begin
            m_prio[i] = 0; m_pend[i] = 0; m_irql[i] = 0; m_lvb[i] = 0;
         end
         m_phase = 0; m_idx = 0; m_req = 0; m_lvl = 0; m_addr = 0;
      end else if (cen) begin
         best = -1; bp = 0;
         for (int i = 0; i < NSRC; i++)
            if (m_pend[i] != 0 && m_prio[i] != 0 && (m_prio[i] > int'(riff) || m_prio[i] == 7)
                && m_prio[i] > bp) begin
               best = i; bp = m_prio[i];
            end
         wn = int'(cra) - int'(CRA_BASE);
         wr = cr_we && wn >= 0 && wn < NSRC;
         for (int i = 0; i < NSRC; i++) begin
            if (m_lvb[i] != 0) m_pend[i] = int'(irq[i]);
            else if (m_phase == 2 && m_idx == i) m_pend[i] = 0;
            else if (irq[i] && m_irql[i] == 0) m_pend[i] = 1;
            else if (wr && wn == i && crin[7]) m_pend[i] = 0;
            m_irql[i] = int'(irq[i]);
         end
         if (wr) begin
            m_prio[wn] = int'(crin[2:0]);
`ifdef INTCTL_LEVEL_EN
            m_lvb[wn] = int'(crin[3]);
`endif
         end
         if (m_phase == 0) begin
            if (best >= 0) begin
               m_phase = 1; m_req = 1; m_idx = best;
               m_lvl  = (bp == 7) ? 7 : bp + 1;
               m_addr = (int'(VBASE) + 4 * best) % 256;
            end
         end else if (m_phase == 1) begin
            if (int_ack) begin m_phase = 2; m_req = 0; end
         end else begin
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check("int_req",  int'(int_req),  m_req);
         check("int_lvl",  int'(int_lvl),  m_lvl);
         check("int_addr", int'(int_addr), m_addr);
         check("cr_hit",   int'(cr_hit),   exp_hit(cra));
         check("cr_rd",    int'(cr_rd),    exp_rd(cra));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic set_cra(input logic [7:0] a);
      #1 cra = a; #1;
   endtask

   task automatic cr_write(input int n, input logic [31:0] d);
      #1 cra = CRA_BASE + 8'(n); crin = d; cr_we = 1'b1;
      tick();
      cr_we = 1'b0;
   endtask

   task automatic pulse(input logic [NSRC-1:0] m);
      #1 irq = irq | m;
      tick();
      irq = irq & ~m;
   endtask

   task automatic do_ack();
      #1 int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      int k = 0;
      settle();
      while (!int_req && k < 20) begin settle(); k++; end
      if (!int_req) check(nm, 0, 1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;

      // reset state and address decode boundaries
      settle();
      check("rst_req", int_req, 0);
      check("rst_lvl", int_lvl, 0);
      check("rst_addr", int_addr, 0);
      set_cra(8'h72);
      check("hit_in", cr_hit, 1);
      check("rd_rst", cr_rd, 0);
      set_cra(8'h6F); check("hit_lo", cr_hit, 0);
      set_cra(8'h78); check("hit_hi", cr_hit, 0);
      set_cra(8'h77); check("hit_top", cr_hit, 1);

      // basic edge, two-cycle latency, vector and level
      cr_write(2, 32'h5);
      riff = 3'd3;
      pulse(8'h04);
      settle(); check("lat_1cyc", int_req, 0);
      tick(); settle();
      check("t1_req", int_req, 1);
      check("t1_lvl", int_lvl, 6);
      check("t1_addr", int_addr, 8'h48);
      set_cra(8'h72); check("t1_rd_pend", cr_rd, 8'h85);
      do_ack(); settle();
      check("t1_ack_req", int_req, 0);
      check("t1_hold_lvl", int_lvl, 6);
      tick(); settle();
      check("t1_rd_clr", cr_rd, 8'h05);

      // tie broken by lowest index
      riff = 3'd0;
      cr_write(1, 32'h4);
      cr_write(5, 32'h4);
      pulse(8'h22);
      wait_req("t2_tmo_a");
      check("t2_addr_a", int_addr, 8'h44);
      check("t2_lvl_a", int_lvl, 5);
      do_ack();
      wait_req("t2_tmo_b");
      check("t2_addr_b", int_addr, 8'h54);
      do_ack(); tick();

      // NMI passes riff=7, prio 6 does not
      cr_write(0, 32'h7);
      riff = 3'd7;
      pulse(8'h01);
      wait_req("t3_tmo");
      check("t3_lvl", int_lvl, 7);
      check("t3_addr", int_addr, 8'h40);
      do_ack();
      cr_write(3, 32'h6);
      pulse(8'h08);
      for (int i = 0; i < 4; i++) begin tick(); settle(); check("t3_masked", int_req, 0); end
      cr_write(3, 32'h86);

      // REQ outputs frozen against preemption, prio rewrite and riff change
      riff = 3'd0;
      cr_write(7, 32'h3);
      pulse(8'h80);
      wait_req("t4_tmo_a");
      check("t4_lvl_a", int_lvl, 4);
      check("t4_addr_a", int_addr, 8'h5C);
      pulse(8'h08);
      cr_write(7, 32'h1);
      riff = 3'd5;
      tick(); settle();
      check("t4_frz_req", int_req, 1);
      check("t4_frz_lvl", int_lvl, 4);
      check("t4_frz_addr", int_addr, 8'h5C);
      do_ack();
      riff = 3'd0;
      wait_req("t4_tmo_b");
      check("t4_addr_b", int_addr, 8'h4C);
      check("t4_lvl_b", int_lvl, 7);
      do_ack(); tick();

      // CR write clear vs simultaneous edge
      riff = 3'd7;
      cr_write(4, 32'h2);
      pulse(8'h10);
      set_cra(8'h74); check("t5_pend", cr_rd, 8'h82);
      cr_write(4, 32'h82);
      settle(); check("t5_clr", cr_rd, 8'h02);
      #1 irq[4] = 1'b1; cra = 8'h74; crin = 32'h82; cr_we = 1'b1;
      tick();
      cr_we = 1'b0; irq[4] = 1'b0;
      settle(); check("t5_set_wins", cr_rd, 8'h82);
      cr_write(4, 32'h80);
      settle(); check("t5_zero", cr_rd, 8'h00);
      riff = 3'd0;

`ifdef INTCTL_LEVEL_EN
      // level-sensitive source re-requests while held high
      cr_write(6, 32'h0C);
      #1 irq[6] = 1'b1;
      tick();
      wait_req("t6_tmo");
      check("t6_addr", int_addr, 8'h58);
      check("t6_lvl", int_lvl, 5);
      set_cra(8'h76); check("t6_rd", cr_rd, 8'h8C);
      do_ack(); settle(); check("t6_ack", int_req, 0);
      tick(); settle(); check("t6_idle", int_req, 0);
      tick(); settle(); check("t6_rearm", int_req, 1);
      #1 irq[6] = 1'b0;
      tick();
      do_ack();
      for (int i = 0; i < 4; i++) begin tick(); settle(); check("t6_quiet", int_req, 0); end
`endif

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         cen     = ($urandom_range(7) != 0);
         irq     = NSRC'($urandom & $urandom & $urandom);
         if ($urandom_range(15) == 0) riff = 3'($urandom);
         cr_we   = ($urandom_range(9) == 0);
         cra     = 8'h6C + 8'($urandom_range(15));
         crin    = $urandom;
         int_ack = ($urandom_range(2) == 0);
         if (c == 2000) begin
            rst_n = 1'b0;
            #1;
            check("rnd_rst_req", int_req, 0);
            check("rnd_rst_addr", int_addr, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         tick();
      end
      cen = 1'b1; cr_we = 1'b0; int_ack = 1'b0; irq = '0;
      tick(); settle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
